vram_arbiter: RTL and testbench

Shares the single-port character/colour video RAM (14-bit address, 16-bit word) between the display fetch path and the processor's memory-mapped VRAM port. The display path owns the RAM whenever it requests, so on-screen glyph/colour fetches are never delayed. CPU reads and writes use a req/ack handshake and are slotted into free cycles. Sits between the pixel generator's RAM address/data pins, the CPU bus bridge, and the VRAM block.

---
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display fetches own the single-port RAM, CPU req/ack accesses fill free slots.
// Optional starvation guard enabled by defining VRAM_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_e;

  owner_e            own1_q, own1_d, own2_q;
  logic              we1_q, we2_q;
  logic              cpu_busy_q, cpu_busy_d;
  logic              grant_disp, grant_cpu, force_cpu;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] disp_data_q, cpu_rdata_q;
  logic              disp_valid_q, cpu_ack_q;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          miss1_q, miss2_q, disp_miss_q;

  always_comb begin
    force_cpu = cpu_req & ~cpu_busy_q & (starve_q == LIMIT);
    starve_d  = starve_q;
    if (!cpu_req || grant_cpu)
      starve_d = '0;
    else if (!cpu_busy_q)
      starve_d = starve_q + 1'b1;
  end

  // A forced CPU slot steals the display's fetch; flag it where disp_valid would have risen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      miss1_q     <= 1'b0;
      miss2_q     <= 1'b0;
      disp_miss_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      miss1_q     <= disp_req & force_cpu;
      miss2_q     <= miss1_q;
      disp_miss_q <= miss2_q;
    end
  end

  assign disp_miss = disp_miss_q;
`else
  assign force_cpu = 1'b0;
  assign disp_miss = 1'b0;
`endif

  always_comb begin
    grant_disp = disp_req & ~force_cpu;
    grant_cpu  = cpu_req & ~cpu_busy_q & (~disp_req | force_cpu);
    own1_d     = OWN_NONE;
    if (grant_disp)
      own1_d = OWN_DISP;
    else if (grant_cpu)
      own1_d = OWN_CPU;
    cpu_busy_d = cpu_busy_q;
    if (grant_cpu)
      cpu_busy_d = 1'b1;
    else if (own2_q == OWN_CPU)
      cpu_busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own1_q       <= OWN_NONE;
      own2_q       <= OWN_NONE;
      we1_q        <= 1'b0;
      we2_q        <= 1'b0;
      cpu_busy_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      disp_data_q  <= '0;
      cpu_rdata_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
    end else begin
      ram_we_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      if (grant_disp) begin
        ram_addr_q <= disp_addr;
      end else if (grant_cpu) begin
        ram_addr_q  <= cpu_addr;
        ram_we_q    <= cpu_we;
        ram_wdata_q <= cpu_wdata;
      end
      own1_q     <= own1_d;
      we1_q      <= grant_cpu & cpu_we;
      own2_q     <= own1_q;
      we2_q      <= we1_q;
      cpu_busy_q <= cpu_busy_d;
      case (own2_q)
        OWN_DISP: begin
          disp_data_q  <= ram_rdata;
          disp_valid_q <= 1'b1;
        end
        OWN_CPU: begin
          cpu_ack_q <= 1'b1;
          if (!we2_q)
            cpu_rdata_q <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural VRAM, vector table plus corner-case sequences, queue scoreboard.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_req, cpu_req, cpu_we;
  logic [13:0] disp_addr, cpu_addr, ram_addr;
  logic [15:0] disp_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        disp_valid, disp_miss, cpu_ack, ram_we;

  vram_arbiter #(.ADDR_W(14), .DATA_W(16), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_miss(disp_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency and a bench-side preload port.
  logic [15:0] mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t dq[$];
  exp_t cq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int ack_seen = 0, valid_seen = 0, we_seen = 0, miss_seen = 0, miss_cyc = -1;
  logic [15:0] exp_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ram_we) we_seen++;
      if (disp_miss) begin miss_seen++; miss_cyc = cyc; end
      if (disp_valid) begin
        valid_seen++;
        if (dq.size() == 0) fail("disp_valid_unexpected");
        else begin
          e = dq.pop_front();
          check("disp_valid_time", 32'(cyc), 32'(e.due));
          check("disp_data", 32'(disp_data), 32'(e.data));
        end
      end else if (dq.size() != 0 && dq[0].due <= cyc) begin
        fail("disp_valid_missing");
        void'(dq.pop_front());
      end
      if (cpu_ack) begin
        ack_seen++;
        if (cq.size() == 0) fail("cpu_ack_unexpected");
        else begin
          e = cq.pop_front();
          check("cpu_ack_time", 32'(cyc), 32'(e.due));
          check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
        end
      end else if (cq.size() != 0 && cq[0].due <= cyc) begin
        fail("cpu_ack_missing");
        void'(cq.pop_front());
      end
    end
  end

  task automatic push_d(input int due, input logic [15:0] d);
    exp_t e; e.due = due; e.data = d; dq.push_back(e);
  endtask

  task automatic push_c(input int due, input logic [15:0] d);
    exp_t e; e.due = due; e.data = d; cq.push_back(e);
  endtask

  task automatic cpu_op(input logic we, input logic [13:0] a, input logic [15:0] d, input logic [15:0] rexp);
    int w0;
    bit got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (!we) exp_rdata = rexp;
    push_c(cyc + 3, exp_rdata);
    w0 = we_seen; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
    end
    cpu_req = 1'b0;
    if (!got) fail("cpu_ack_timeout");
    check("ram_we_pulses", 32'(we_seen - w0), {31'd0, we});
  endtask

  task automatic disp_op(input logic [13:0] a, input logic [15:0] exp);
    @(negedge clk);
    disp_req = 1'b1; disp_addr = a;
    push_d(cyc + 3, exp);
    @(negedge clk);
    disp_req = 1'b0;
    check("ram_addr_disp", 32'(ram_addr), 32'(a));
    repeat (3) @(negedge clk);
  endtask

  typedef struct { bit is_disp; logic we; logic [13:0] addr; logic [15:0] wdata; logic [15:0] exp; } vec_t;
  vec_t vec [9];

  initial begin
    int c, a0, v0, m0, nack;
    bit got;
    int skip, cdue, mexp;

    vec[0] = '{1'b0, 1'b1, 14'h1F3F, 16'h7C1F, 16'h0000};
    vec[1] = '{1'b0, 1'b0, 14'h1F3F, 16'h0000, 16'h7C1F};
    vec[2] = '{1'b1, 1'b0, 14'h1F3F, 16'h0000, 16'h7C1F};
    vec[3] = '{1'b0, 1'b1, 14'h0000, 16'hFFFF, 16'h0000};
    vec[4] = '{1'b0, 1'b1, 14'h3FFF, 16'hA5A5, 16'h0000};
    vec[5] = '{1'b0, 1'b0, 14'h3FFF, 16'h0000, 16'hA5A5};
    vec[6] = '{1'b0, 1'b0, 14'h0000, 16'h0000, 16'hFFFF};
    vec[7] = '{1'b1, 1'b0, 14'h3FFF, 16'h0000, 16'hA5A5};
    vec[8] = '{1'b1, 1'b0, 14'h0000, 16'h0000, 16'hFFFF};

    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vec[i].is_disp) disp_op(vec[i].addr, vec[i].exp);
      else cpu_op(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].exp);
    end

    // Display read of preloaded word; data must persist between fetches.
    @(negedge clk); pre_we = 1'b1; pre_addr = 14'h00A5; pre_data = 16'h8123;
    @(negedge clk); pre_we = 1'b0;
    disp_op(14'h00A5, 16'h8123);
    repeat (8) @(negedge clk);
    check("disp_data_hold", 32'(disp_data), 32'h8123);

    // Simultaneous requests: display first, CPU one edge later.
    @(negedge clk);
    c = cyc;
    disp_req = 1'b1; disp_addr = 14'h00A5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1F3F;
    exp_rdata = 16'h7C1F;
    push_d(c + 3, 16'h8123);
    push_c(c + 4, 16'h7C1F);
    @(negedge clk); disp_req = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (cpu_ack) got = 1; end
    cpu_req = 1'b0;
    if (!got) fail("conflict_ack_timeout");
    repeat (2) @(negedge clk);

    // Held CPU request: three reads, acks three cycles apart.
    @(negedge clk);
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0000; exp_rdata = 16'hFFFF;
    push_c(c + 3, 16'hFFFF); push_c(c + 6, 16'hFFFF); push_c(c + 9, 16'hFFFF);
    nack = 0;
    for (int i = 0; i < 20 && nack < 3; i++) begin
      @(negedge clk);
      if (cpu_ack) nack++;
    end
    cpu_req = 1'b0;
    check("b2b_ack_count", 32'(nack), 32'd3);
    repeat (3) @(negedge clk);

    // Display saturation with a pending CPU read.
`ifdef VRAM_STARVE_GUARD_EN
    skip = 9; mexp = 1;
`else
    skip = 0; mexp = 0;
`endif
    @(negedge clk);
    c = cyc;
    cdue = (skip != 0) ? c + skip + 2 : c + 53;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3FFF; exp_rdata = 16'hA5A5;
    push_c(cdue, 16'hA5A5);
    m0 = miss_seen; got = 0;
    for (int i = 0; i < 50; i++) begin
      disp_req = 1'b1; disp_addr = 14'h00A5;
      if (i + 1 != skip) push_d(c + i + 3, 16'h8123);
      @(negedge clk);
      if (cpu_ack) begin got = 1; cpu_req = 1'b0; end
    end
    disp_req = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
    if (!got) fail("sat_ack_timeout");
    check("sat_miss_count", 32'(miss_seen - m0), 32'(mexp));
    if (mexp != 0) check("sat_miss_time", 32'(miss_cyc), 32'(c + skip + 2));
    repeat (4) @(negedge clk);
    check("disp_data_after_sat", 32'(disp_data), 32'h8123);

    // Reset during an outstanding CPU read aborts it.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1F3F;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ram_addr", 32'(ram_addr), 32'd0);
    check("abort_ram_we", 32'(ram_we), 32'd0);
    check("abort_ram_wdata", 32'(ram_wdata), 32'd0);
    check("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    check("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("abort_disp_data", 32'(disp_data), 32'd0);
    check("abort_disp_valid", 32'(disp_valid), 32'd0);
    check("abort_disp_miss", 32'(disp_miss), 32'd0);
    cpu_req = 1'b0;
    exp_rdata = '0;
    a0 = ack_seen; v0 = valid_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_ack", 32'(ack_seen - a0), 32'd0);
    check("abort_no_valid", 32'(valid_seen - v0), 32'd0);

    cpu_op(1'b0, 14'h1F3F, 16'h0000, 16'h7C1F);
    repeat (4) @(negedge clk);
    check("disp_queue_drained", 32'(dq.size()), 32'd0);
    check("cpu_queue_drained", 32'(cq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
